mnist_stream_scoreboard: RTL

- Synthesizable stimulus streamer and result scoreboard for the MNIST inference core, used for on-FPGA accuracy runs.
- Reads labelled samples from an external sample memory.
- Streams each sample's pixels over a valid/ready interface with an inter-sample gap.
- Waits for the core's classification with a timeout, compares it to the label, and keeps running correct/total/timeout counts. All of this is parametrised in width, sample size, sample count, gap and timeout.

---
 rtl/mnist_stream_scoreboard.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mnist_stream_scoreboard.sv
// rtl/mnist_stream_scoreboard.sv - sample streamer and result scoreboard for MNIST accuracy runs
module mnist_stream_scoreboard #(
    parameter int DATA_WIDTH     = 16,
    parameter int PIX_PER_SAMPLE = 784,
    parameter int NUM_SAMPLES    = 1000,
    parameter int GAP_CYCLES     = 200,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MEM_ADDR_WIDTH = 20,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [DATA_WIDTH-1:0]     pix_data,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    input  logic [DATA_WIDTH-1:0]     res_data,
    input  logic                      res_valid,
    output logic [CNT_WIDTH-1:0]      correct_cnt,
    output logic [CNT_WIDTH-1:0]      total_cnt,
    output logic [CNT_WIDTH-1:0]      timeout_cnt,
    output logic                      spurious_err
);

    localparam int PIX_W = $clog2(PIX_PER_SAMPLE + 1);
    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int K_W   = (NUM_SAMPLES < 2) ? 1 : $clog2(NUM_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_LABEL, S_LABEL_CAP, S_STREAM, S_WAIT_RES, S_NEXT, S_DONE
    } state_t;

    state_t state, state_next;

    logic [K_W-1:0]            k;
    logic [MEM_ADDR_WIDTH-1:0] base;
    logic [GAP_W-1:0]          gap_cnt;
    logic [TMO_W-1:0]          tmo_cnt;
    logic [PIX_W-1:0]          rd_cnt;
    logic [PIX_W-1:0]          xfer_cnt;
    logic [DATA_WIDTH-1:0]     label;
    logic [DATA_WIDTH-1:0]     buf0, buf1;
    logic [1:0]                occ;
    logic                      inflight;
    logic                      pop, last_pop, rd_issue, timed_out, last_sample;
    logic [2:0]                slots;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign pix_valid = (occ != 2'd0);
    assign pix_data  = buf0;
    assign pop       = pix_valid && pix_ready;
    assign last_pop  = pop && (xfer_cnt == PIX_W'(PIX_PER_SAMPLE - 1));
    assign timed_out = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign last_sample = (k == K_W'(NUM_SAMPLES - 1));

    // Count the slot freed by this cycle's pop so a full-rate stream never bubbles.
    assign slots    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign rd_issue = (state == S_STREAM) && (rd_cnt != PIX_W'(PIX_PER_SAMPLE)) && (slots < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        case (state)
            S_IDLE:      if (start) state_next = (GAP_CYCLES == 0) ? S_LABEL : S_GAP;
            S_GAP:       if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_next = S_LABEL;
            S_LABEL: begin
                mem_rd_en  = 1'b1;
                mem_addr   = base + MEM_ADDR_WIDTH'(PIX_PER_SAMPLE);
                state_next = S_LABEL_CAP;
            end
            S_LABEL_CAP: state_next = S_STREAM;
            S_STREAM: begin
                if (rd_issue) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = base + MEM_ADDR_WIDTH'(rd_cnt);
                end
                if (last_pop) state_next = S_WAIT_RES;
            end
            S_WAIT_RES:  if (res_valid || timed_out) state_next = S_NEXT;
            S_NEXT: begin
                if (last_sample)          state_next = S_DONE;
                else if (GAP_CYCLES == 0) state_next = S_LABEL;
                else                      state_next = S_GAP;
            end
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k            <= '0;
            base         <= '0;
            gap_cnt      <= '0;
            tmo_cnt      <= '0;
            rd_cnt       <= '0;
            xfer_cnt     <= '0;
            label        <= '0;
            buf0         <= '0;
            buf1         <= '0;
            occ          <= '0;
            inflight     <= 1'b0;
            done         <= 1'b0;
            correct_cnt  <= '0;
            total_cnt    <= '0;
            timeout_cnt  <= '0;
            spurious_err <= 1'b0;
        end else begin
            // Read data returns one cycle after the strobe; inflight marks it as a pixel.
            inflight <= rd_issue;
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= mem_rdata;
                    else             buf1 <= mem_rdata;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= mem_rdata;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= mem_rdata;
                    end
                end
                default: ;
            endcase

            gap_cnt  <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
            tmo_cnt  <= (state == S_WAIT_RES) ? tmo_cnt + TMO_W'(1) : '0;
            rd_cnt   <= (state != S_STREAM) ? '0 : (rd_issue ? rd_cnt + PIX_W'(1) : rd_cnt);
            xfer_cnt <= (state != S_STREAM) ? '0 : (pop ? xfer_cnt + PIX_W'(1) : xfer_cnt);

            if (state == S_LABEL_CAP) label <= mem_rdata;

            if (state == S_IDLE && start) begin
                k            <= '0;
                base         <= '0;
                done         <= 1'b0;
                correct_cnt  <= '0;
                total_cnt    <= '0;
                timeout_cnt  <= '0;
                spurious_err <= 1'b0;
            end

            if (state == S_WAIT_RES) begin
                if (res_valid) begin
                    total_cnt <= sat_inc(total_cnt);
                    if (res_data == label) correct_cnt <= sat_inc(correct_cnt);
                end else if (timed_out) begin
                    total_cnt   <= sat_inc(total_cnt);
                    timeout_cnt <= sat_inc(timeout_cnt);
                end
            end

            if (state == S_NEXT) begin
                if (last_sample) begin
                    done <= 1'b1;
                end else begin
                    k    <= k + K_W'(1);
                    base <= base + MEM_ADDR_WIDTH'(PIX_PER_SAMPLE + 1);
                end
            end

            if (res_valid && state != S_WAIT_RES) spurious_err <= 1'b1;
        end
    end

endmodule
